stopwatch_sequencer: RTL and testbench



---
 rtl/stopwatch_sequencer_pkg.sv | 23 ++
 rtl/stopwatch_sequencer_if.sv | 25 ++
 rtl/stopwatch_sequencer_cond.sv | 32 +++
 rtl/stopwatch_sequencer.sv | 147 ++++++++++++++
 tb/tb_stopwatch_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_sequencer_pkg.sv
// stopwatch_pkg: state encoding and default timing constants shared by the
// stopwatch sequencer and the display controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HOLD = 2'd3
    } sw_state_e;

    localparam int unsigned TICK_DIV_DEFAULT      = 100000;
    localparam int unsigned REPEAT_DELAY_DEFAULT  = 500;
    localparam int unsigned REPEAT_PERIOD_DEFAULT = 100;

    // Width of a counter that must hold values 0..maxVal, never narrower than 1 bit.
    function automatic int unsigned cntWidth(input int unsigned maxVal);
        int unsigned w;
        w = $clog2(maxVal + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stopwatch_sequencer_if.sv
// Button inputs and control outputs of the stopwatch sequencer.
// master: the side driving the buttons; slave: the sequencer itself.
interface stopwatch_sequencer_if;

    logic       start_i;
    logic       stop_i;
    logic       incre_i;
    logic       lap_i;
    logic       count_en_o;
    logic       capture_o;
    logic       freeze_o;
    logic       run_o;
    logic [1:0] state_o;

    modport master (
        output start_i, stop_i, incre_i, lap_i,
        input  count_en_o, capture_o, freeze_o, run_o, state_o
    );

    modport slave (
        input  start_i, stop_i, incre_i, lap_i,
        output count_en_o, capture_o, freeze_o, run_o, state_o
    );

endinterface

// File: rtl/stopwatch_sequencer_cond.sv
// button_conditioner: two-flop synchronizer for a raw asynchronous button,
// followed by a third flop for rising-edge detection. A held button yields a
// single rise pulse; a re-press needs at least one low synced cycle.
module button_conditioner (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    // Synchronizer chain plus one delay stage for the edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign level_o = sync2_q;
    assign rise_o  = sync2_q & ~sync3_q;

endmodule

// File: rtl/stopwatch_sequencer.sv
// stopwatch_sequencer: conditions the start/stop/incre/lap buttons, derives
// count ticks from a free-running divider and runs the IDLE/RUN/STEP/HOLD
// mode machine. All outputs are registered one-cycle pulses or levels.
// Optional feature macro: STOPWATCH_SEQ_AUTOREPEAT_EN enables incre
// auto-repeat while in HOLD.
module stopwatch_sequencer
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV      = TICK_DIV_DEFAULT,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    stopwatch_sequencer_if.slave bus
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    // Reject parameter values the divider and repeat counter cannot handle.
    if (TICK_DIV < 2 || TICK_DIV > (1 << 20) || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badParams
        $error("stopwatch_sequencer: illegal TICK_DIV/REPEAT_DELAY/REPEAT_PERIOD");
    end

    logic startLevel, startRise;
    logic stopLevel,  stopRise;
    logic increLevel, increRise;
    logic lapLevel,   lapRise;

    button_conditioner u_condStart (.clk(clk), .rst(rst), .btn_i(bus.start_i), .level_o(startLevel), .rise_o(startRise));
    button_conditioner u_condStop  (.clk(clk), .rst(rst), .btn_i(bus.stop_i),  .level_o(stopLevel),  .rise_o(stopRise));
    button_conditioner u_condIncre (.clk(clk), .rst(rst), .btn_i(bus.incre_i), .level_o(increLevel), .rise_o(increRise));
    button_conditioner u_condLap   (.clk(clk), .rst(rst), .btn_i(bus.lap_i),   .level_o(lapLevel),   .rise_o(lapRise));

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;

    assign tick  = (div_q == DIV_W'(TICK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    // Free-running tick divider; it ignores the mode so ticks stay evenly spaced.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

`ifdef STOPWATCH_SEQ_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = cntWidth(REP_MAX);

    logic [REP_W-1:0] repCnt_q;
    logic             repeating_q;
`endif

    sw_state_e state_q;
    logic      countEn_q;
    logic      capture_q;
    logic      freeze_q;
    logic      run_q;

    // Mode machine with registered outputs, including the HOLD repeat counter when built.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            countEn_q   <= 1'b0;
            capture_q   <= 1'b0;
            freeze_q    <= 1'b0;
            run_q       <= 1'b0;
`ifdef STOPWATCH_SEQ_AUTOREPEAT_EN
            repCnt_q    <= '0;
            repeating_q <= 1'b0;
`endif
        end else begin
            countEn_q <= 1'b0;
            capture_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (startRise) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end else if (increRise) begin
                        state_q   <= STEP;
                        countEn_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (stopRise) begin
                        state_q  <= IDLE;
                        run_q    <= 1'b0;
                        freeze_q <= 1'b0;
                    end else begin
                        countEn_q <= tick;
                        if (lapRise) begin
                            if (!freeze_q) begin
                                capture_q <= 1'b1;
                                freeze_q  <= 1'b1;
                            end else begin
                                freeze_q  <= 1'b0;
                            end
                        end
                    end
                end
                STEP: begin
                    state_q <= HOLD;
`ifdef STOPWATCH_SEQ_AUTOREPEAT_EN
                    repCnt_q    <= '0;
                    repeating_q <= 1'b0;
`endif
                end
                HOLD: begin
                    if (!increLevel) begin
                        state_q <= IDLE;
                    end
`ifdef STOPWATCH_SEQ_AUTOREPEAT_EN
                    else if (tick) begin
                        if (!repeating_q && repCnt_q == REP_W'(REPEAT_DELAY - 1)) begin
                            countEn_q   <= 1'b1;
                            repeating_q <= 1'b1;
                            repCnt_q    <= '0;
                        end else if (repeating_q && repCnt_q == REP_W'(REPEAT_PERIOD - 1)) begin
                            countEn_q   <= 1'b1;
                            repCnt_q    <= '0;
                        end else if (repCnt_q != '1) begin
                            repCnt_q    <= repCnt_q + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count_en_o = countEn_q;
    assign bus.capture_o  = capture_q;
    assign bus.freeze_o   = freeze_q;
    assign bus.run_o      = run_q;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// tb_stopwatch_sequencer: table-driven button vectors with a queue of
// expected results, plus hand-written reset, latency and HOLD sequences.
module tb_stopwatch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    stopwatch_sequencer_if bus();

    stopwatch_sequencer #(
        .TICK_DIV(4),
        .REPEAT_DELAY(3),
        .REPEAT_PERIOD(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string      name;
        logic [3:0] btn;
        int         holdCyc;
        int         waitCyc;
        logic [1:0] expState;
        logic       expFreeze;
        logic       expRun;
        int         expEn;
        int         expCap;
    } vec_t;

    typedef struct {
        string      name;
        logic [1:0] state;
        logic       freeze;
        logic       run;
        int         en;
        int         cap;
    } exp_t;

    exp_t scoreQ[$];
    vec_t vecs[15];

    int total = 0;
    int bad   = 0;
    int enSeen  = 0;
    int capSeen = 0;

    // Pulse counters sampled away from the rising edge.
    always @(negedge clk) begin
        if (bus.count_en_o === 1'b1) enSeen++;
        if (bus.capture_o === 1'b1) capSeen++;
    end

    // Reference tick/synchronizer timing used to predict auto-repeat pulses.
    int   divM = 0;
    logic incD1 = 1'b0;
    logic incD2 = 1'b0;
    int   holdTicks = 0;
    always @(posedge clk) begin
        if (rst) begin
            divM  <= 0;
            incD1 <= 1'b0;
            incD2 <= 1'b0;
        end else begin
            if (bus.state_o == 2'd3 && incD2 && divM == 3) holdTicks <= holdTicks + 1;
            divM  <= (divM == 3) ? 0 : divM + 1;
            incD1 <= bus.incre_i;
            incD2 <= incD1;
        end
    end

    task automatic driveButtons(input logic [3:0] b);
        {bus.start_i, bus.stop_i, bus.incre_i, bus.lap_i} = b;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        e.name   = v.name;
        e.state  = v.expState;
        e.freeze = v.expFreeze;
        e.run    = v.expRun;
        e.en     = v.expEn;
        e.cap    = v.expCap;
        scoreQ.push_back(e);
        enSeen  = 0;
        capSeen = 0;
        driveButtons(v.btn);
        repeat (v.holdCyc) nextCycle();
        driveButtons(4'b0000);
        repeat (v.waitCyc) nextCycle();
    endtask

    task automatic checkOutput();
        exp_t e;
        e = scoreQ.pop_front();
        check({e.name, ".state"},  bus.state_o,  e.state);
        check({e.name, ".freeze"}, bus.freeze_o, e.freeze);
        check({e.name, ".run"},    bus.run_o,    e.run);
        check({e.name, ".capture"}, capSeen,     e.cap);
        if (e.en >= 0) check({e.name, ".count_en"}, enSeen, e.en);
    endtask

    initial begin
        int expPulses;
        int reached;

        // btn = {start, stop, incre, lap}; expEn -1 means pulse count not checked.
        vecs[0]  = '{"idleQuiet",   4'b0000, 1, 8, 2'd0, 1'b0, 1'b0,  0, 0};
        vecs[1]  = '{"start",       4'b1000, 1, 5, 2'd1, 1'b0, 1'b1, -1, 0};
        vecs[2]  = '{"run40",       4'b0000, 40, 0, 2'd1, 1'b0, 1'b1, 10, 0};
        vecs[3]  = '{"lap1",        4'b0001, 1, 5, 2'd1, 1'b1, 1'b1, -1, 1};
        vecs[4]  = '{"lap2",        4'b0001, 1, 5, 2'd1, 1'b0, 1'b1, -1, 0};
        vecs[5]  = '{"lapStop",     4'b0101, 1, 5, 2'd0, 1'b0, 1'b0, -1, 0};
        vecs[6]  = '{"stopped20",   4'b0000, 20, 0, 2'd0, 1'b0, 1'b0,  0, 0};
        vecs[7]  = '{"restart",     4'b1000, 1, 5, 2'd1, 1'b0, 1'b1, -1, 0};
        vecs[8]  = '{"lap3",        4'b0001, 1, 5, 2'd1, 1'b1, 1'b1, -1, 1};
        vecs[9]  = '{"stopFrozen",  4'b0100, 1, 5, 2'd0, 1'b0, 1'b0, -1, 0};
        vecs[10] = '{"increTap",    4'b0010, 1, 6, 2'd0, 1'b0, 1'b0,  1, 0};
        vecs[11] = '{"startIncre",  4'b1010, 1, 5, 2'd1, 1'b0, 1'b1, -1, 0};
        vecs[12] = '{"stop2",       4'b0100, 1, 5, 2'd0, 1'b0, 1'b0, -1, 0};
        vecs[13] = '{"idle20",      4'b0000, 20, 0, 2'd0, 1'b0, 1'b0,  0, 0};
        vecs[14] = '{"idleStopLap", 4'b0101, 1, 5, 2'd0, 1'b0, 1'b0,  0, 0};

        // Reset with every button pressed; nothing may leak through afterwards.
        driveButtons(4'b1111);
        rst = 1'b1;
        nextCycle();
        nextCycle();
        rst = 1'b0;
        driveButtons(4'b0000);
        check("rst.state",    bus.state_o,    2'd0);
        check("rst.count_en", bus.count_en_o, 1'b0);
        check("rst.capture",  bus.capture_o,  1'b0);
        check("rst.freeze",   bus.freeze_o,   1'b0);
        check("rst.run",      bus.run_o,      1'b0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            check("postRst.state",    bus.state_o,    2'd0);
            check("postRst.count_en", bus.count_en_o, 1'b0);
        end

        // Button-to-state latency: state changes only after the third edge.
        driveButtons(4'b1000);
        nextCycle();
        driveButtons(4'b0000);
        check("lat.edge1", bus.state_o, 2'd0);
        nextCycle();
        check("lat.edge2", bus.state_o, 2'd0);
        nextCycle();
        check("lat.edge3", bus.state_o, 2'd1);
        check("lat.run",   bus.run_o,   1'b1);
        driveButtons(4'b0100);
        nextCycle();
        driveButtons(4'b0000);
        repeat (5) nextCycle();
        check("lat.stopped", bus.state_o, 2'd0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Single incre tap: STEP with one pulse, then HOLD, then back to IDLE.
        driveButtons(4'b0010);
        nextCycle();
        driveButtons(4'b0000);
        nextCycle();
        nextCycle();
        check("tap.stateStep", bus.state_o,    2'd2);
        check("tap.enStep",    bus.count_en_o, 1'b1);
        nextCycle();
        check("tap.stateHold", bus.state_o,    2'd3);
        check("tap.enHold",    bus.count_en_o, 1'b0);
        nextCycle();
        check("tap.stateIdle", bus.state_o,    2'd0);

        // incre held for 20 ticks.
        enSeen    = 0;
        holdTicks = 0;
        driveButtons(4'b0010);
        repeat (80) nextCycle();
        driveButtons(4'b0000);
        repeat (8) nextCycle();
`ifdef STOPWATCH_SEQ_AUTOREPEAT_EN
        expPulses = 1 + ((holdTicks >= 3) ? 1 + (holdTicks - 3) / 2 : 0);
`else
        expPulses = 1;
`endif
        check("held.count_en", enSeen, expPulses);
        check("held.state",    bus.state_o, 2'd0);

        // Reset in the middle of HOLD while incre is still held.
        driveButtons(4'b0010);
        reached = 0;
        for (int i = 0; i < 20 && reached == 0; i++) begin
            nextCycle();
            if (bus.state_o == 2'd3) reached = 1;
        end
        check("rstHold.reached", reached, 1);
        repeat (10) nextCycle();
        rst = 1'b1;
        nextCycle();
        check("rstHold.state",    bus.state_o,    2'd0);
        check("rstHold.count_en", bus.count_en_o, 1'b0);
        rst = 1'b0;
        driveButtons(4'b0000);
        enSeen = 0;
        repeat (12) nextCycle();
        check("rstHold.quietEn", enSeen,      0);
        check("rstHold.idle",    bus.state_o, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
